aes_host_if: RTL
================

Name: aes_host_if

Overview:
- APB slave register bank and transfer sequencer that sits directly upstream of the AES control unit.
- Holds the CR/SR, key and IV registers.
- Assembles four DINR writes into a 128-bit block and pulses start to the control unit.
- Captures the 128-bit result on end_comp and serves it back as four DOUTR reads, raising status flags and an interrupt.

Parameters:
- DW, 32, APB data width (fixed; block words are 4×DW = 128 bits)
- AW, 4, APB word-address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB write strobe
- paddr  in  4  word index: 0 CR, 1 SR, 2 DINR, 3 DOUTR, 4-7 KEYR0-3, 8-11 IVR0-3
- pwdata  in  32  write data
- prdata  out  32  read data (combinational from registers)
- pready  out  1  tied 1
- pslverr  out  1  tied 0
- start  out  1  one-cycle start pulse to control unit
- disable_core  out  1  equal to ~CR.EN
- operation_mode  out  2  CR.MODE
- aes_mode  out  2  CR.CHMOD
- data_in  out  128  assembled input block; word 0 is [127:96]
- key  out  128  KEYR3..KEYR0; KEYR3 is [127:96]
- iv  out  128  IVR3..IVR0
- end_comp  in  1  control-unit completion strobe
- key_derivation_en  in  1  load derived key
- data_out  in  128  result block
- key_out  in  128  derived key
- irq  out  1  registered interrupt

Behaviour:
- **APB:** write commits when psel&penable&pwrite; read access when psel&penable&!pwrite. Unmapped addresses (12-15) read 0, writes ignored.
- **CR fields:** [0] EN, [2:1] MODE, [4:3] CHMOD, [7] CCFC, [8] ERRC, [9] CCFIE, [10] ERRIE.
  - CCFC/ERRC are write-only self-clearing and read 0.
  - While EN=1, writes to MODE/CHMOD are ignored; EN and the IE bits remain writable.
- **SR fields:** [0] CCF, [1] RDERR, [2] WRERR, [3] BUSY (state==BUSY). Read-only.
- **KEYR/IVR:** writable only while EN=0; writes with EN=1 are silently dropped. key_derivation_en=1 loads key <= key_out in that cycle, with priority over an APB write.
- **FSM** (2-bit word counter wcnt):
  - **IDLE:** waits for EN=1.
    - DINR write: store at word wcnt, wcnt++, go to INPUT.
    - MODE=01 (key derivation) on the cycle EN rises 0→1: pulse start, go to BUSY.
  - **INPUT:** each DINR write stores word wcnt and wcnt++. The write with wcnt==3 wraps wcnt to 0, pulses start on the next cycle (registered), and goes to BUSY.
  - **BUSY:** on end_comp, capture data_out into the result register, set CCF, wcnt=0.
    - If MODE==01: go to IDLE.
    - Otherwise: go to OUTPUT.
  - **OUTPUT:** each DOUTR read returns word wcnt and wcnt++. The read with wcnt==3 wraps wcnt and returns to IDLE.
- **Errors:**
  - DINR write in BUSY or OUTPUT sets WRERR; data is dropped.
  - DOUTR read outside OUTPUT sets RDERR; prdata=0 and the counter is unchanged.
- **Flag clear:** CCFC clears CCF and ERRC clears RDERR/WRERR. If a set event coincides with a clear in the same cycle, set wins.
- **EN deasserted (write 0):** in any state, next cycle state=IDLE and wcnt=0. Input and result registers and SR flags are retained. No start is issued.
- **start:** exactly one cycle wide, never asserted while state==BUSY.
- **irq:** registered, (CCF&CCFIE)|((RDERR|WRERR)&ERRIE); 1-cycle lag from the flag.
- **Reset values:** all registers, outputs, and flags are 0; state=IDLE; wcnt=0; disable_core=1 (EN=0); irq=0; start=0.

Test Plan:
1. **Encrypt path:** write KEYR0-3; write CR=0x001 (EN, MODE=00, ECB); write DINR 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF → data_in=0x00112233_44556677_8899AABB_CCDDEEFF, start high exactly 1 cycle after the 4th write, SR=0x8.
2. **Completion and readout:** drive end_comp with data_out=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A, CCFIE=1 → SR.CCF=1 and irq=1 one cycle later. Four DOUTR reads return words in order, then state IDLE. Writing CR with CCFC=1 → CCF=0, irq=0.
3. **Error flags:**
   - DINR write during BUSY → WRERR=1 and data_in unchanged.
   - DOUTR read in IDLE → prdata=0, RDERR=1.
   - ERRC write → both flags cleared.
4. **Key derivation:** CR=0x003 (EN rising with MODE=01) → start pulse. key_derivation_en with key_out=0xD014F9A8_C9EE2589_E13F0CC8_B6630CA6 → key equals key_out, CCF=1, state IDLE.
5. **Abort and locks:**
   - After 2 DINR writes, write CR.EN=0 → disable_core=1 next cycle, wcnt=0, no start.
   - A KEYR write while EN=1 is ignored.
6. **Reset mid-BUSY and clear/set collision:**
   - Assert rst_n low mid-BUSY → all outputs return to reset values asynchronously.
   - end_comp coinciding with a CCFC write → CCF=1.

Source files
------------

// File: rtl/aes_host_if.sv
// aes_host_if: APB register bank and block sequencer in front of the AES
// control unit.
//
// Holds the CR/SR, key and IV registers. Four DINR writes are gathered into
// a 128-bit block, and then start is pulsed. The result is captured on
// end_comp and read back as four DOUTR reads.
//
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   psel/penable/pwrite    APB control
//   paddr/pwdata/prdata    APB word address, write data, read data
//   pready/pslverr         tied 1 / 0
//   start                  one-cycle start pulse to the control unit
//   disable_core           ~CR.EN
//   operation_mode/aes_mode CR.MODE / CR.CHMOD
//   data_in/key/iv         assembled block, key and IV (word 0 / reg 3 at MSBs)
//   end_comp               completion strobe, captures data_out
//   key_derivation_en      loads key from key_out
//   irq                    registered interrupt
//
// state  | meaning
// IDLE   | waiting for EN and the first DINR write (or key-derivation start)
// INPUT  | collecting DINR words; start is issued after the fourth
// BUSY   | control unit running, waiting for end_comp
// OUTPUT | serving result words on DOUTR reads
module aes_host_if #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic          start,
  output logic          disable_core,
  output logic [1:0]    operation_mode,
  output logic [1:0]    aes_mode,
  output logic [127:0]  data_in,
  output logic [127:0]  key,
  output logic [127:0]  iv,
  input  logic          end_comp,
  input  logic          key_derivation_en,
  input  logic [127:0]  data_out,
  input  logic [127:0]  key_out,
  output logic          irq
);

  typedef enum logic [1:0] {S_IDLE, S_INPUT, S_BUSY, S_OUTPUT} state_t;

  state_t       state_q, state_d;
  logic [1:0]   wcnt_q, wcnt_d;
  logic         start_q, start_d;
  logic         cr_en, cr_ccfie, cr_errie;
  logic [1:0]   cr_mode, cr_chmod;
  logic         ccf, rderr, wrerr, irq_q;
  logic [127:0] din_q, dout_q, key_q, iv_q;
  logic         din_we, cap, wrerr_set, rderr_set;

  logic wr_acc, rd_acc, cr_wr, din_wr, dout_rd, en_off, kd_go;
  logic key_wr, iv_wr;
  logic [6:0] word_lsb, reg_lsb;
  logic unused_bits;

  assign wr_acc  = psel & penable & pwrite;
  assign rd_acc  = psel & penable & ~pwrite;
  assign cr_wr   = wr_acc && (paddr == AW'(0));
  assign din_wr  = wr_acc && (paddr == AW'(2));
  assign dout_rd = rd_acc && (paddr == AW'(3));
  assign key_wr  = wr_acc && !cr_en && (paddr[AW-1:2] == (AW-2)'(1));
  assign iv_wr   = wr_acc && !cr_en && (paddr[AW-1:2] == (AW-2)'(2));
  assign en_off  = cr_wr && !pwdata[0];
  // Key derivation starts on the write that raises EN with MODE=01.
  assign kd_go   = cr_wr && !cr_en && pwdata[0] && (pwdata[2:1] == 2'b01);

  // Block word 0 sits at the MSBs; KEYR/IVR 0 sit at the LSBs.
  assign word_lsb = {~wcnt_q, 5'd0};
  assign reg_lsb  = {paddr[1:0], 5'd0};

  assign unused_bits = ^{pwdata[DW-1:11], pwdata[6:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
    end
  end

  // While start_q is high the FSM is still in IDLE/INPUT and moves to BUSY
  // on the next edge, so start never overlaps BUSY. A DINR write in that
  // cycle is treated as a write while busy.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    start_d   = 1'b0;
    din_we    = 1'b0;
    cap       = 1'b0;
    wrerr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d   = S_BUSY;
          wrerr_set = din_wr;
        end else if (kd_go) begin
          start_d = 1'b1;
        end else if (din_wr && cr_en) begin
          din_we  = 1'b1;
          wcnt_d  = wcnt_q + 2'd1;
          state_d = S_INPUT;
        end
      end
      S_INPUT: begin
        if (start_q) begin
          state_d   = S_BUSY;
          wrerr_set = din_wr;
        end else if (din_wr) begin
          din_we  = 1'b1;
          wcnt_d  = wcnt_q + 2'd1;
          start_d = (wcnt_q == 2'd3);
        end
      end
      S_BUSY: begin
        wrerr_set = din_wr;
        if (end_comp) begin
          cap     = 1'b1;
          wcnt_d  = 2'd0;
          state_d = (cr_mode == 2'b01) ? S_IDLE : S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        wrerr_set = din_wr;
        if (dout_rd) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (en_off) begin
      state_d = S_IDLE;
      wcnt_d  = 2'd0;
      start_d = 1'b0;
      din_we  = 1'b0;
    end
  end

  assign rderr_set = dout_rd && (state_q != S_OUTPUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_en    <= 1'b0;
      cr_mode  <= 2'b00;
      cr_chmod <= 2'b00;
      cr_ccfie <= 1'b0;
      cr_errie <= 1'b0;
      ccf      <= 1'b0;
      rderr    <= 1'b0;
      wrerr    <= 1'b0;
      irq_q    <= 1'b0;
      din_q    <= '0;
      dout_q   <= '0;
      key_q    <= '0;
      iv_q     <= '0;
    end else begin
      if (cr_wr) begin
        cr_en    <= pwdata[0];
        cr_ccfie <= pwdata[9];
        cr_errie <= pwdata[10];
        if (!cr_en) begin
          cr_mode  <= pwdata[2:1];
          cr_chmod <= pwdata[4:3];
        end
      end
      // Set events win over a clear in the same cycle.
      if (cap)                        ccf <= 1'b1;
      else if (cr_wr && pwdata[7])    ccf <= 1'b0;
      if (rderr_set)                  rderr <= 1'b1;
      else if (cr_wr && pwdata[8])    rderr <= 1'b0;
      if (wrerr_set)                  wrerr <= 1'b1;
      else if (cr_wr && pwdata[8])    wrerr <= 1'b0;
      irq_q <= (ccf & cr_ccfie) | ((rderr | wrerr) & cr_errie);
      if (din_we) din_q[word_lsb +: 32] <= pwdata;
      if (cap)    dout_q <= data_out;
      if (key_derivation_en) key_q <= key_out;
      else if (key_wr)       key_q[reg_lsb +: 32] <= pwdata;
      if (iv_wr)  iv_q[reg_lsb +: 32] <= pwdata;
    end
  end

  always_comb begin
    prdata = '0;
    case (paddr)
      AW'(0):  prdata = DW'({cr_errie, cr_ccfie, 2'b00, 2'b00, cr_chmod, cr_mode, cr_en});
      AW'(1):  prdata = DW'({state_q == S_BUSY, wrerr, rderr, ccf});
      AW'(3):  prdata = (state_q == S_OUTPUT) ? dout_q[word_lsb +: 32] : '0;
      AW'(4), AW'(5), AW'(6), AW'(7):  prdata = key_q[reg_lsb +: 32];
      AW'(8), AW'(9), AW'(10), AW'(11): prdata = iv_q[reg_lsb +: 32];
      default: prdata = '0;
    endcase
  end

  assign pready         = 1'b1;
  assign pslverr        = 1'b0;
  assign start          = start_q;
  assign disable_core   = ~cr_en;
  assign operation_mode = cr_mode;
  assign aes_mode       = cr_chmod;
  assign data_in        = din_q;
  assign key            = key_q;
  assign iv             = iv_q;
  assign irq            = irq_q;

endmodule
